// File: rtl/alu_pkg.sv
// Shared encodings for the ALU sequencer: request ops, ALU commands, states, status codes.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package alu_pkg;

    localparam int DATA_W = 15;

    // Request opcodes; 5..7 are illegal
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_MUL = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4;

    // ALU command inputs
    localparam logic [2:0] CMD_ADD = 3'd0;
    localparam logic [2:0] CMD_SUB = 3'd1;
    localparam logic [2:0] CMD_AND = 3'd2;
    localparam logic [2:0] CMD_MP0 = 3'd3;
    localparam logic [2:0] CMD_MP1 = 3'd4;
    localparam logic [2:0] CMD_DV0 = 3'd5;
    localparam logic [2:0] CMD_DV1 = 3'd6;

    // Response status
    localparam logic [1:0] STAT_OK       = 2'b00;
    localparam logic [1:0] STAT_PAR_ERR  = 2'b01;
    localparam logic [1:0] STAT_ILLEGAL  = 2'b10;
    localparam logic [1:0] STAT_DIV_ZERO = 2'b11;

    // +0 in ones' complement with odd parity attached
    localparam logic [15:0] WORD_POS_ZERO = 16'h0001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // ALU command for a given op on its first or second pass.
    // MUL yields low then high product; DIV yields quotient then remainder.
    function automatic logic [2:0] pass_cmd(input logic [2:0] op, input logic second);
        logic [2:0] cmd;
        cmd = CMD_ADD;
        case (op)
            OP_SUB:  cmd = CMD_SUB;
            OP_AND:  cmd = CMD_AND;
            OP_MUL:  cmd = second ? CMD_MP1 : CMD_MP0;
            OP_DIV:  cmd = second ? CMD_DV0 : CMD_DV1;
            default: cmd = CMD_ADD;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/odd_parity.sv
// Builds an odd-parity word {d, ~^d} from a data magnitude.
// Latency: combinational.
// Backpressure: none.
module odd_parity #(
    parameter int DATA_W = 15
) (
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W:0]   word_o
);

    // Parity bit chosen so the XOR of the whole word is 1
    assign word_o = {data_i, ~^data_i};

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one request through the ones'-complement ALU (1 or 2 passes) and returns hi/lo words.
// Latency: accept->rsp_valid 1 cycle on error, 2 cycles single-pass, 3 cycles MUL/DIV.
// Backpressure: one request in flight; req_ready only in IDLE, response held until rsp_ready.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W       = 15,
    parameter bit CHECK_PARITY = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [DATA_W:0]   req_a,
    input  logic [DATA_W:0]   req_b,
    output logic [DATA_W:0]   alu_a,
    output logic [DATA_W:0]   alu_b,
    output logic [2:0]        alu_cmd,
    input  logic [DATA_W-1:0] alu_res,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W:0]   rsp_hi,
    output logic [DATA_W:0]   rsp_lo,
    output logic [1:0]        rsp_status
);

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W:0]   alu_a_q, alu_a_d;
    logic [DATA_W:0]   alu_b_q, alu_b_d;
    logic [DATA_W:0]   rsp_hi_q, rsp_hi_d;
    logic [DATA_W:0]   rsp_lo_q, rsp_lo_d;
    logic [1:0]        rsp_status_q, rsp_status_d;

    logic [DATA_W:0]   a_chk_word, b_chk_word, res_word;
    logic              a_par_err, b_par_err, div_zero;
    logic [1:0]        acc_status;

    // A received word is bad when it differs from its data with correct parity re-attached
    odd_parity #(.DATA_W(DATA_W)) u_par_a   (.data_i(req_a[DATA_W:1]), .word_o(a_chk_word));
    odd_parity #(.DATA_W(DATA_W)) u_par_b   (.data_i(req_b[DATA_W:1]), .word_o(b_chk_word));
    odd_parity #(.DATA_W(DATA_W)) u_par_res (.data_i(alu_res),         .word_o(res_word));

    assign a_par_err = (a_chk_word != req_a);
    assign b_par_err = (b_chk_word != req_b);
    // Both +0 and -0 divisors are rejected
    assign div_zero  = (req_op == OP_DIV) &&
                       ((req_b[DATA_W:1] == '0) || (&req_b[DATA_W:1]));

    // Error checks on the incoming request, highest priority first
    always_comb begin
        acc_status = STAT_OK;
        if (req_op > OP_DIV) begin
            acc_status = STAT_ILLEGAL;
        end else if (CHECK_PARITY && (a_par_err || b_par_err)) begin
            acc_status = STAT_PAR_ERR;
        end else if (div_zero) begin
            acc_status = STAT_DIV_ZERO;
        end
    end

    // Next-state and datapath capture for the sequencer
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_hi_d     = rsp_hi_q;
        rsp_lo_d     = rsp_lo_q;
        rsp_status_d = rsp_status_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    alu_a_d      = req_a;
                    alu_b_d      = req_b;
                    op_d         = req_op;
                    rsp_hi_d     = WORD_POS_ZERO;
                    rsp_lo_d     = WORD_POS_ZERO;
                    rsp_status_d = acc_status;
                    state_d      = (acc_status == STAT_OK) ? ST_PASS1 : ST_RESP;
                end
            end
            ST_PASS1: begin
                if (op_q == OP_MUL) begin
                    rsp_lo_d = res_word;
                    state_d  = ST_PASS2;
                end else if (op_q == OP_DIV) begin
                    rsp_hi_d = res_word;
                    state_d  = ST_PASS2;
                end else begin
                    rsp_hi_d = res_word;
                    state_d  = ST_RESP;
                end
            end
            ST_PASS2: begin
                if (op_q == OP_MUL) begin
                    rsp_hi_d = res_word;
                end else begin
                    rsp_lo_d = res_word;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ALU command is only non-idle during the compute passes
    always_comb begin
        alu_cmd = CMD_ADD;
        if (state_q == ST_PASS1) begin
            alu_cmd = pass_cmd(op_q, 1'b0);
        end else if (state_q == ST_PASS2) begin
            alu_cmd = pass_cmd(op_q, 1'b1);
        end
    end

    // State and datapath registers; reset returns everything to idle with +0 results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_ADD;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_hi_q     <= WORD_POS_ZERO;
            rsp_lo_q     <= WORD_POS_ZERO;
            rsp_status_q <= STAT_OK;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_hi_q     <= rsp_hi_d;
            rsp_lo_q     <= rsp_lo_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = (state_q == ST_RESP);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp_hi     = rsp_hi_q;
    assign rsp_lo     = rsp_lo_q;
    assign rsp_status = rsp_status_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed cases plus randomized requests checked against a reference model.
// Latency: n/a.
// Backpressure: randomized rsp_ready hold-off.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // Parity-checking instance
    logic        req_valid, req_ready, rsp_valid, rsp_ready;
    logic [2:0]  req_op, alu_cmd;
    logic [15:0] req_a, req_b, alu_a, alu_b, rsp_hi, rsp_lo;
    logic [14:0] alu_res;
    logic [1:0]  rsp_status;

    // Parity-ignoring instance
    logic        p_req_valid, p_req_ready, p_rsp_valid, p_rsp_ready;
    logic [2:0]  p_req_op, p_alu_cmd;
    logic [15:0] p_req_a, p_req_b, p_alu_a, p_alu_b, p_rsp_hi, p_rsp_lo;
    logic [14:0] p_alu_res;
    logic [1:0]  p_rsp_status;

    int n_chk = 0;
    int n_bad = 0;

    alu_op_sequencer #(.DATA_W(15), .CHECK_PARITY(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_res(alu_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_status(rsp_status)
    );

    alu_op_sequencer #(.DATA_W(15), .CHECK_PARITY(1'b0)) u_dut_nopar (
        .clk(clk), .rst_n(rst_n),
        .req_valid(p_req_valid), .req_ready(p_req_ready), .req_op(p_req_op),
        .req_a(p_req_a), .req_b(p_req_b),
        .alu_a(p_alu_a), .alu_b(p_alu_b), .alu_cmd(p_alu_cmd), .alu_res(p_alu_res),
        .rsp_valid(p_rsp_valid), .rsp_ready(p_rsp_ready),
        .rsp_hi(p_rsp_hi), .rsp_lo(p_rsp_lo), .rsp_status(p_rsp_status)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Ones'-complement add with end-around carry
    function automatic logic [14:0] oc_add(input logic [14:0] a, input logic [14:0] b);
        logic [15:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[14:0] + {14'd0, s[15]};
    endfunction

    function automatic logic [15:0] mkw(input logic [14:0] d);
        return {d, ~^d};
    endfunction

    // Behavioural stand-in for the ALU, keyed by command number
    function automatic logic [14:0] alu_stub(input logic [2:0] cmd, input logic [14:0] a, input logic [14:0] b);
        logic [29:0] p;
        logic [14:0] r;
        p = {15'd0, a} * {15'd0, b};
        case (cmd)
            3'd0:    r = oc_add(a, b);
            3'd1:    r = oc_add(a, ~b);
            3'd2:    r = a & b;
            3'd3:    r = p[14:0];
            3'd4:    r = p[29:15];
            3'd5:    r = (b == 15'd0) ? 15'd0 : a % b;
            3'd6:    r = (b == 15'd0) ? 15'd0 : a / b;
            default: r = 15'd0;
        endcase
        return r;
    endfunction

    assign alu_res   = alu_stub(alu_cmd, alu_a[15:1], alu_b[15:1]);
    assign p_alu_res = alu_stub(p_alu_cmd, p_alu_a[15:1], p_alu_b[15:1]);

    // Reference: expected response and ALU command trace for one request
    task automatic ref_model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                             input bit par_on,
                             output logic [15:0] hi, output logic [15:0] lo, output logic [1:0] st,
                             output int lat, output int ncmd, output logic [2:0] c0, output logic [2:0] c1);
        logic [14:0] da, db;
        logic [29:0] p;
        da = a[15:1];
        db = b[15:1];
        p  = {15'd0, da} * {15'd0, db};
        hi = 16'h0001; lo = 16'h0001; c0 = 3'd0; c1 = 3'd0; ncmd = 0; lat = 1;
        if (op > 3'd4)                                         st = 2'b10;
        else if (par_on && ((^a == 1'b0) || (^b == 1'b0)))     st = 2'b01;
        else if (op == 3'd4 && (db == 15'd0 || db == 15'h7FFF)) st = 2'b11;
        else                                                   st = 2'b00;
        if (st == 2'b00) begin
            case (op)
                3'd0: begin hi = mkw(oc_add(da, db));  lat = 2; ncmd = 1; c0 = 3'd0; end
                3'd1: begin hi = mkw(oc_add(da, ~db)); lat = 2; ncmd = 1; c0 = 3'd1; end
                3'd2: begin hi = mkw(da & db);         lat = 2; ncmd = 1; c0 = 3'd2; end
                3'd3: begin lo = mkw(p[14:0]); hi = mkw(p[29:15]); lat = 3; ncmd = 2; c0 = 3'd3; c1 = 3'd4; end
                default: begin hi = mkw(da / db); lo = mkw(da % db); lat = 3; ncmd = 2; c0 = 3'd6; c1 = 3'd5; end
            endcase
        end
    endtask

    // Drive one request into the parity-checking instance and check its whole life cycle.
    // Entered and left at a negedge with the DUT idle.
    task automatic run_req(input string tag, input logic [2:0] op, input logic [15:0] a,
                           input logic [15:0] b, input int hold,
                           output logic [15:0] got_hi, output logic [15:0] got_lo, output logic [1:0] got_st);
        logic [15:0] e_hi, e_lo;
        logic [1:0]  e_st;
        int          e_lat, e_ncmd, lat;
        logic [2:0]  e_c0, e_c1;
        logic [2:0]  seen[$];
        ref_model(op, a, b, 1'b1, e_hi, e_lo, e_st, e_lat, e_ncmd, e_c0, e_c1);
        check({tag, ":req_ready_idle"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk);
        @(negedge clk);
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            seen.push_back(alu_cmd);
            check({tag, ":alu_a"}, {16'd0, alu_a}, {16'd0, a});
            check({tag, ":alu_b"}, {16'd0, alu_b}, {16'd0, b});
            // Request and response inputs outside their states must be ignored
            req_valid = 1'($urandom_range(0, 1));
            req_op = 3'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
            rsp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        rsp_ready = 1'b0;
        check({tag, ":rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, ":latency"}, lat, e_lat);
        check({tag, ":n_passes"}, seen.size(), e_ncmd);
        if (seen.size() > 0 && e_ncmd > 0) check({tag, ":cmd0"}, {29'd0, seen[0]}, {29'd0, e_c0});
        if (seen.size() > 1 && e_ncmd > 1) check({tag, ":cmd1"}, {29'd0, seen[1]}, {29'd0, e_c1});
        check({tag, ":cmd_resp"}, {29'd0, alu_cmd}, 32'd0);
        check({tag, ":status"}, {30'd0, rsp_status}, {30'd0, e_st});
        check({tag, ":hi"}, {16'd0, rsp_hi}, {16'd0, e_hi});
        check({tag, ":lo"}, {16'd0, rsp_lo}, {16'd0, e_lo});
        got_hi = rsp_hi; got_lo = rsp_lo; got_st = rsp_status;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_op = 3'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
            @(negedge clk);
            check({tag, ":hold_valid"}, {31'd0, rsp_valid}, 32'd1);
            check({tag, ":hold_ready"}, {31'd0, req_ready}, 32'd0);
            check({tag, ":hold_data"}, {rsp_hi, rsp_lo}, {e_hi, e_lo});
            check({tag, ":hold_st"}, {30'd0, rsp_status}, {30'd0, e_st});
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, ":post_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, ":post_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] h, l;
        logic [1:0]  s;
        logic [14:0] da, db;
        logic [2:0]  op;
        logic [15:0] wa, wb;
        int          r, w;

        rst_n = 1'b0;
        req_valid = 1'b0; req_op = 3'd0; req_a = 16'd0; req_b = 16'd0; rsp_ready = 1'b0;
        p_req_valid = 1'b0; p_req_op = 3'd0; p_req_a = 16'd0; p_req_b = 16'd0; p_rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst:req_ready", {31'd0, req_ready}, 32'd1);
        check("rst:rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst:alu", {alu_a, alu_b}, 32'd0);
        check("rst:cmd", {29'd0, alu_cmd}, 32'd0);
        check("rst:rsp", {rsp_hi, rsp_lo}, 32'h0001_0001);
        check("rst:status", {30'd0, rsp_status}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_req("add", 3'd0, 16'h0007, 16'h0008, 0, h, l, s);
        check("add:const", {h, l}, 32'h000E_0001);
        run_req("mul", 3'd3, 16'h0007, 16'h0008, 0, h, l, s);
        check("mul:const", {h, l}, 32'h0001_0019);
        run_req("div", 3'd4, 16'h001A, 16'h0008, 0, h, l, s);
        check("div:const", {h, l}, 32'h0007_0002);
        run_req("dz_pos", 3'd4, 16'h001A, 16'h0001, 0, h, l, s);
        check("dz_pos:const", {14'd0, s}, 32'd3);
        run_req("dz_neg", 3'd4, 16'h001A, 16'hFFFE, 1, h, l, s);
        check("dz_neg:const", {14'd0, s}, 32'd3);
        run_req("par", 3'd0, 16'h0006, 16'h0008, 0, h, l, s);
        check("par:const", {14'd0, s}, 32'd1);
        run_req("ill", 3'd7, 16'h0006, 16'h0008, 0, h, l, s);
        check("ill:const", {14'd0, s}, 32'd2);
        run_req("bp", 3'd1, 16'h0007, 16'h0008, 5, h, l, s);

        // Parity ignored: bad operand still computes 3 + 4
        p_req_valid = 1'b1; p_req_op = 3'd0; p_req_a = 16'h0006; p_req_b = 16'h0008;
        @(posedge clk);
        @(negedge clk);
        p_req_valid = 1'b0;
        w = 0;
        while (!p_rsp_valid && w < 8) begin
            @(negedge clk);
            w++;
        end
        check("nopar:valid", {31'd0, p_rsp_valid}, 32'd1);
        check("nopar:result", {p_rsp_hi, p_rsp_lo}, 32'h000E_0001);
        check("nopar:status", {30'd0, p_rsp_status}, 32'd0);
        p_rsp_ready = 1'b1;
        @(negedge clk);
        p_rsp_ready = 1'b0;
        check("nopar:post_ready", {31'd0, p_req_ready}, 32'd1);

        // Asynchronous reset during the second pass of a multiply
        req_valid = 1'b1; req_op = 3'd3; req_a = mkw(15'd100); req_b = mkw(15'd200);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("mrst:in_pass2", {29'd0, alu_cmd}, 32'd4);
        #2 rst_n = 1'b0;
        #1;
        check("mrst:req_ready", {31'd0, req_ready}, 32'd1);
        check("mrst:rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mrst:alu", {alu_a, alu_b}, 32'd0);
        check("mrst:cmd", {29'd0, alu_cmd}, 32'd0);
        check("mrst:rsp", {rsp_hi, rsp_lo}, 32'h0001_0001);
        check("mrst:status", {30'd0, rsp_status}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_req("post_rst_add", 3'd0, 16'h0007, 16'h0008, 0, h, l, s);

        // Randomized requests
        for (int i = 0; i < 80; i++) begin
            r  = $urandom_range(0, 11);
            op = (r >= 8) ? 3'(r - 8) : 3'(r);
            da = 15'($urandom);
            db = 15'($urandom);
            if ($urandom_range(0, 7) == 0) db = ($urandom_range(0, 1) == 1) ? 15'h7FFF : 15'h0000;
            wa = mkw(da);
            wb = mkw(db);
            if ($urandom_range(0, 7) == 0) wa[0] = ~wa[0];
            if ($urandom_range(0, 7) == 0) wb[0] = ~wb[0];
            run_req("rand", op, wa, wb, $urandom_range(0, 3), h, l, s);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
